// File: rtl/drum_pkg.sv
// Shared types and constants for the drum-pad conditioner.
package drum_pkg;

  localparam int NUM_DRUMS = 3;
  localparam int DEBOUNCE_10MS = 250000;

  typedef enum logic [1:0] {
    KICK  = 2'd0,
    SNARE = 2'd1,
    HAT   = 2'd2
  } drum_e;

  typedef enum logic [1:0] {
    LOW,
    RISE_WAIT,
    HIGH,
    FALL_WAIT
  } deb_state_e;

endpackage

// File: rtl/drum_hit_conditioner_if.sv
// Pad-side inputs and display-side outputs of the drum-hit conditioner.
interface drum_hit_conditioner_if #(
  parameter int NUM_CH = 3,
  parameter int CNT_W  = 8
);
  logic [NUM_CH-1:0]       hit_raw_i;
  logic                    frame_start;
  logic                    clear_counts;
  logic [NUM_CH-1:0]       hit_level_o;
  logic [NUM_CH-1:0]       hit_pulse_o;
  logic                    any_hit_o;
  logic [NUM_CH-1:0]       flash_o;
  logic [NUM_CH*CNT_W-1:0] count_o;

  modport master (
    output hit_raw_i, frame_start, clear_counts,
    input  hit_level_o, hit_pulse_o, any_hit_o, flash_o, count_o
  );

  modport slave (
    input  hit_raw_i, frame_start, clear_counts,
    output hit_level_o, hit_pulse_o, any_hit_o, flash_o, count_o
  );
endinterface

// File: rtl/debounce_ch.sv
// One pad channel: 2-flop synchroniser, debounce FSM and rising-edge pulse.
//   state     | meaning
//   LOW       | debounced level 0
//   RISE_WAIT | sync=1 seen, counting stable high cycles
//   HIGH      | debounced level 1
//   FALL_WAIT | sync=0 seen, counting stable low cycles
module debounce_ch
  import drum_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_10MS
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic pulse,
  output logic rise
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES);

  logic       s1, s2;
  deb_state_e state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic       level_nxt;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1    <= 1'b0;
      s2    <= 1'b0;
      state <= LOW;
      cnt   <= '0;
      level <= 1'b0;
      pulse <= 1'b0;
    end else begin
      s1    <= raw;
      s2    <= s1;
      state <= state_nxt;
      cnt   <= cnt_nxt;
      level <= level_nxt;
      pulse <= rise;
    end
  end

  // The qualifying sample is the one that brings the count to DEBOUNCE_CYCLES,
  // so the transition happens on that same edge rather than one later.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      LOW: begin
        if (s2) begin
          if (CNT_ONE == CNT_MAX) begin
            state_nxt = HIGH;
            cnt_nxt   = '0;
          end else begin
            state_nxt = RISE_WAIT;
            cnt_nxt   = CNT_ONE;
          end
        end
      end
      RISE_WAIT: begin
        if (!s2) begin
          state_nxt = LOW;
          cnt_nxt   = '0;
        end else if (cnt + CNT_ONE == CNT_MAX) begin
          state_nxt = HIGH;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      HIGH: begin
        if (!s2) begin
          if (CNT_ONE == CNT_MAX) begin
            state_nxt = LOW;
            cnt_nxt   = '0;
          end else begin
            state_nxt = FALL_WAIT;
            cnt_nxt   = CNT_ONE;
          end
        end
      end
      FALL_WAIT: begin
        if (s2) begin
          state_nxt = HIGH;
          cnt_nxt   = '0;
        end else if (cnt + CNT_ONE == CNT_MAX) begin
          state_nxt = LOW;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      default: begin
        state_nxt = LOW;
        cnt_nxt   = '0;
      end
    endcase
  end

  // rise is the strobe that becomes pulse on the next edge; the top uses it to
  // load the flash counter so flash_o comes up together with hit_pulse_o.
  always_comb begin
    level_nxt = (state_nxt == HIGH) || (state_nxt == FALL_WAIT);
    rise      = level_nxt & ~level;
  end
endmodule

// File: rtl/drum_hit_conditioner.sv
// Debounced drum-pad hits with per-channel flash flags and frame-latched counts.
module drum_hit_conditioner
  import drum_pkg::*;
#(
  parameter int NUM_CH          = NUM_DRUMS,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_10MS,
  parameter int FLASH_FRAMES    = 8,
  parameter int CNT_W           = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  drum_hit_conditioner_if.slave  bus
);
  localparam int FL_W = (FLASH_FRAMES > 0) ? $clog2(FLASH_FRAMES + 1) : 1;
  localparam logic [FL_W-1:0]  FL_LOAD = FL_W'(FLASH_FRAMES);
  localparam logic [CNT_W-1:0] CNT_SAT = '1;

  logic [NUM_CH-1:0] level, pulse, rise;
  logic [FL_W-1:0]   flash_cnt [NUM_CH];
  logic [CNT_W-1:0]  live      [NUM_CH];
  logic [CNT_W-1:0]  count_ch  [NUM_CH];

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    debounce_ch #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb (
      .clk  (clk),
      .reset(reset),
      .raw  (bus.hit_raw_i[g]),
      .level(level[g]),
      .pulse(pulse[g]),
      .rise (rise[g])
    );

    // Live count follows the registered pulse, so a frame_start in the pulse
    // cycle still latches the pre-hit value.
    always_ff @(posedge clk) begin
      if (reset) begin
        flash_cnt[g] <= '0;
        live[g]      <= '0;
        count_ch[g]  <= '0;
      end else begin
        if (rise[g])
          flash_cnt[g] <= FL_LOAD;
        else if (bus.frame_start && flash_cnt[g] != '0)
          flash_cnt[g] <= flash_cnt[g] - 1'b1;

        if (bus.clear_counts)
          live[g] <= '0;
        else if (pulse[g] && live[g] != CNT_SAT)
          live[g] <= live[g] + 1'b1;

        if (bus.frame_start)
          count_ch[g] <= live[g];
      end
    end

    assign bus.flash_o[g]                 = (flash_cnt[g] != '0);
    assign bus.count_o[g*CNT_W +: CNT_W]  = count_ch[g];
  end

  assign bus.hit_level_o = level;
  assign bus.hit_pulse_o = pulse;
  assign bus.any_hit_o   = |pulse;
endmodule
